// File: rtl/off_chip_link_pkg.sv
// off_chip_link_pkg: lane-map helpers, derived sizes and mode encodings
package off_chip_link_pkg;
  localparam int MAX_W = 64;
  localparam int IDX_W = $clog2(MAX_W);
  localparam logic MODE_CONTIG = 1'b0;
  localparam logic MODE_ILV = 1'b1;
  typedef logic [MAX_W-1:0] wide_t;
  typedef logic [IDX_W-1:0] idx_t;
  function automatic int nphit_of(input int data_w, input int phit_w);
    return data_w / phit_w;
  endfunction
  function automatic int ptr_w_of(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic idx_t bit_of(input int j, input int k, input int data_w, input int phit_w, input logic mode);
    return idx_t'(mode == MODE_ILV ? j * (data_w / phit_w) + k : k * phit_w + j);
  endfunction
  function automatic wide_t phit_of(input wide_t data, input int k, input int data_w, input int phit_w, input logic mode);
    wide_t p = '0;
    for (int j = 0; j < phit_w; j++) p[idx_t'(j)] = data[bit_of(j, k, data_w, phit_w, mode)];
    return p;
  endfunction
  function automatic wide_t word_of(input wide_t word, input wide_t phit, input int k, input int data_w, input int phit_w, input logic mode);
    wide_t w = word;
    for (int j = 0; j < phit_w; j++) w[bit_of(j, k, data_w, phit_w, mode)] = phit[idx_t'(j)];
    return w;
  endfunction
endpackage

// File: rtl/off_chip_link_gen2_if.sv
// off_chip_link_gen2_if: upstream/downstream handshakes and link status
interface off_chip_link_gen2_if #(parameter int DATA_W = 8, parameter int DEPTH = 8);
  logic [DATA_W-1:0] data_in, data_out;
  logic valid_in, in_ready, cfg_interleave, valid_out, ready, link_idle;
  logic [$clog2(DEPTH):0] credit_cnt;
  modport master(output data_in, valid_in, cfg_interleave, ready, input in_ready, data_out, valid_out, credit_cnt, link_idle);
  modport slave(input data_in, valid_in, cfg_interleave, ready, output in_ready, data_out, valid_out, credit_cnt, link_idle);
endinterface

// File: rtl/off_chip_link_buf.sv
// off_chip_link_buf: phit buffer with synchronous write and combinational read
module off_chip_link_buf #(parameter int PHIT_W = 2, parameter int DEPTH = 8) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  input  logic [PHIT_W-1:0] wdata,
  output logic [PHIT_W-1:0] rdata
);
  logic [PHIT_W-1:0] mem [DEPTH];
  // write port; reset clears every entry
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/off_chip_link_gen2.sv
// off_chip_link_gen2: word serialiser, credit-controlled phit buffer and reassembler
import off_chip_link_pkg::*;
module off_chip_link_gen2 #(parameter int DATA_W = 8, parameter int PHIT_W = 2, parameter int DEPTH = 8) (
  input logic clk,
  input logic rst,
  off_chip_link_gen2_if.slave bus
);
  localparam int NPHIT = nphit_of(DATA_W, PHIT_W);
  localparam int PTR_W = ptr_w_of(DEPTH);
  localparam int IW = $clog2(NPHIT);
  localparam logic [IW-1:0] LAST = IW'(NPHIT - 1);
  logic [DATA_W-1:0] tx_word, rx_asm, rx_word, data_q;
  logic [IW-1:0] tx_idx, rx_idx;
  logic [PTR_W-1:0] wptr, rptr, credit_cnt;
  logic [PHIT_W-1:0] tx_phit, rx_phit;
  logic tx_busy, mode_q, ret, issue, tx_last, accept, pop, rx_last, empty, full, valid_q;
  assign issue = tx_busy && credit_cnt != '0;
  assign tx_last = issue && tx_idx == LAST;
  assign bus.in_ready = !tx_busy || tx_last;
  assign accept = bus.valid_in && bus.in_ready;
  assign empty = wptr == rptr;
  assign full = wptr == {~rptr[PTR_W-1], rptr[PTR_W-2:0]};
  assign rx_last = rx_idx == LAST;
  assign pop = !empty && (!rx_last || !valid_q || bus.ready);
  assign bus.link_idle = !tx_busy && empty && rx_idx == '0;
  assign bus.credit_cnt = credit_cnt;
  assign bus.valid_out = valid_q;
  assign bus.data_out = data_q;
  assign tx_phit = PHIT_W'(phit_of(wide_t'(tx_word), int'(tx_idx), DATA_W, PHIT_W, mode_q));
  assign rx_word = DATA_W'(word_of(wide_t'(rx_asm), wide_t'(rx_phit), int'(rx_idx), DATA_W, PHIT_W, mode_q));
  off_chip_link_buf #(.PHIT_W(PHIT_W), .DEPTH(DEPTH)) u_buf (
    .clk(clk), .rst(rst), .we(issue), .waddr(wptr[PTR_W-2:0]), .raddr(rptr[PTR_W-2:0]),
    .wdata(tx_phit), .rdata(rx_phit)
  );
  // TX: take a word when free or on its last phit, then issue one phit per credited cycle
  always_ff @(posedge clk)
    if (rst) begin
      tx_busy <= 1'b0;
      tx_idx <= '0;
      tx_word <= '0;
    end else if (accept) begin
      tx_busy <= 1'b1;
      tx_idx <= '0;
      tx_word <= bus.data_in;
    end else if (issue) begin
      tx_busy <= !tx_last;
      tx_idx <= tx_last ? '0 : tx_idx + 1'b1;
    end
  // lane map follows cfg only while the whole link is empty
  always_ff @(posedge clk)
    if (rst) mode_q <= MODE_CONTIG;
    else if (bus.link_idle) mode_q <= bus.cfg_interleave;
  // pointers, credit counter and the one-cycle-late credit return
  always_ff @(posedge clk)
    if (rst) begin
      credit_cnt <= PTR_W'(DEPTH);
      ret <= 1'b0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      credit_cnt <= credit_cnt - PTR_W'(issue) + PTR_W'(ret);
      ret <= pop;
      wptr <= wptr + PTR_W'(issue);
      rptr <= rptr + PTR_W'(pop);
    end
  // RX: assemble phits; the last phit waits for the output register to be free
  always_ff @(posedge clk)
    if (rst) begin
      rx_idx <= '0;
      rx_asm <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (pop) rx_idx <= rx_last ? '0 : rx_idx + 1'b1;
      if (pop) rx_asm <= rx_word;
      if (pop && rx_last) data_q <= rx_word;
      valid_q <= (pop && rx_last) || (valid_q && !bus.ready);
    end
  // credits stay in range and never allow a write into a full buffer
  always_ff @(posedge clk)
    if (!rst) begin
      assert (credit_cnt <= PTR_W'(DEPTH));
      assert (!(issue && full));
      assert (!(ret && !issue && credit_cnt == PTR_W'(DEPTH)));
    end
endmodule

// File: tb/tb_off_chip_link_gen2.sv
// tb_off_chip_link_gen2: scoreboard bench for the serialising credit link
module tb_off_chip_link_gen2;
  localparam int DW = 8, PW = 2, DP = 8, NP = 4;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  off_chip_link_gen2_if #(.DATA_W(DW), .DEPTH(DP)) bus();
  off_chip_link_gen2 #(.DATA_W(DW), .PHIT_W(PW), .DEPTH(DP)) dut (.clk(clk), .rst(rst), .bus(bus));
  int total = 0, bad = 0, cyc = 0, acc_cyc = 0, lat = 0, vcnt = 0, n_out = 0, n_acc = 0;
  logic [7:0] exp_q[$];
  logic prev_v = 1'b0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      n_acc = 0;
      prev_v = 1'b0;
    end else begin
      if (bus.valid_in && bus.in_ready) begin
        exp_q.push_back(bus.data_in);
        acc_cyc = cyc;
        n_acc++;
      end
      if (bus.valid_out) vcnt++;
      if (bus.valid_out && !prev_v) lat = cyc - acc_cyc - 1;
      if (bus.valid_out && bus.ready) begin
        n_out++;
        if (exp_q.size() == 0) check("unexpected_out", 32'(exp_q.size()), 32'd1);
        else check("out_word", 32'(bus.data_out), 32'(exp_q.pop_front()));
      end
      prev_v = bus.valid_out;
    end
  end
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_try(input logic [7:0] w, input int budget, output bit ok);
    bus.data_in = w;
    bus.valid_in = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (ok) bus.valid_in = 1'b0;
  endtask
  task automatic send(input logic [7:0] w);
    bit ok;
    send_try(w, 200, ok);
    check("accept", 32'(ok), 32'd1);
  endtask
  task automatic wait_idle();
    int i = 0;
    while (!(bus.link_idle && !bus.valid_out && exp_q.size() == 0) && i < 500) begin
      step();
      i++;
    end
    check("drain", 32'(i < 500), 32'd1);
  endtask
  task automatic check_phits(input string tag, input int base, input logic [7:0] exp);
    logic [2:0] a;
    for (int k = 0; k < NP; k++) begin
      a = 3'(base + k);
      check(tag, 32'(dut.u_buf.mem[a]), 32'(exp[k*PW +: PW]));
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int base, outs;
    bit ok, done;
    bus.data_in = '0;
    bus.valid_in = 1'b0;
    bus.cfg_interleave = 1'b0;
    bus.ready = 1'b1;
    rst = 1'b1;
    step(2);
    check("rst_valid", 32'(bus.valid_out), 32'd0);
    check("rst_data", 32'(bus.data_out), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_credit", 32'(bus.credit_cnt), 32'd8);
    check("rst_idle", 32'(bus.link_idle), 32'd1);
    rst = 1'b0;
    step();
    vcnt = 0;
    base = n_acc * NP;
    send(8'hA5);
    wait_idle();
    check("t2_latency", 32'(lat), 32'd5);
    check("t2_valid_cycles", 32'(vcnt), 32'd1);
    check("t2_credit", 32'(bus.credit_cnt), 32'd8);
    check("t2_idle", 32'(bus.link_idle), 32'd1);
    check_phits("t2_phit", base, 8'hA5);
    bus.cfg_interleave = 1'b1;
    step();
    base = n_acc * NP;
    send(8'h05);
    wait_idle();
    check_phits("t3_phit_05", base, 8'h11);
    base = n_acc * NP;
    send(8'hF0);
    wait_idle();
    check_phits("t3_phit_f0", base, 8'hAA);
    bus.cfg_interleave = 1'b0;
    step();
    bus.ready = 1'b0;
    outs = n_out;
    for (int w = 1; w <= 4; w++) send(8'(w));
    send_try(8'h05, 30, ok);
    check("t4_w5_blocked", 32'(ok), 32'd0);
    check("t4_in_ready", 32'(bus.in_ready), 32'd0);
    check("t4_hold_data", 32'(bus.data_out), 32'h01);
    check("t4_hold_valid", 32'(bus.valid_out), 32'd1);
    check("t4_credit", 32'(bus.credit_cnt), 32'd0);
    check("t4_occupancy", 32'(4'(dut.wptr - dut.rptr)), 32'd8);
    bus.ready = 1'b1;
    send_try(8'h05, 200, ok);
    check("t4_w5_accept", 32'(ok), 32'd1);
    wait_idle();
    check("t4_out_count", 32'(n_out - outs), 32'd5);
    check("t4_credit_end", 32'(bus.credit_cnt), 32'd8);
    send(8'h3C);
    step(2);
    rst = 1'b1;
    step();
    check("t5_valid", 32'(bus.valid_out), 32'd0);
    check("t5_credit", 32'(bus.credit_cnt), 32'd8);
    check("t5_idle", 32'(bus.link_idle), 32'd1);
    check("t5_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    outs = n_out;
    step(20);
    check("t5_no_output", 32'(n_out - outs), 32'd0);
    base = n_acc * NP;
    send(8'h3C);
    bus.cfg_interleave = 1'b1;
    wait_idle();
    check_phits("t6_phit_old_mode", base, 8'h3C);
    step();
    base = n_acc * NP;
    send(8'h3C);
    wait_idle();
    check_phits("t6_phit_new_mode", base, 8'h5A);
    outs = n_out;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) send(8'($urandom));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.ready = 1'($urandom_range(0, 1));
          bus.cfg_interleave = 1'($urandom_range(0, 1));
        end
        bus.ready = 1'b1;
      end
    join
    wait_idle();
    check("rand_out_count", 32'(n_out - outs), 32'd24);
    check("rand_credit", 32'(bus.credit_cnt), 32'd8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
